wb_stage: RTL

- Writeback stage: registered MEM/WB boundary directly upstream of the register file write port.
- Captures one MEM-stage result per cycle, aligns and extends load data, and drives writeEnable/writeAddr/writeValue into the register file one cycle later.
- Suppresses writes to register 0 and writes for misaligned loads.
- Keeps a retired-instruction counter for debug and performance.

---
 rtl/wb_stage.sv | 126 ++++++++++++
 1 files changed

// File: rtl/wb_stage.sv
// wb_stage: registered MEM/WB boundary feeding the register file write port.
// Aligns and extends load data. Suppresses writes to x0 and writes for
// misaligned or reserved-type loads. Counts retired instructions.
// Optional macro WB_FWD_EN adds two same-cycle forwarding read ports that
// expose the value currently being written.
module wb_stage #(
  parameter int WORD_WIDTH  = 32,
  parameter int REG_NUM_LOG = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   inValid,
  input  logic                   flush,
  input  logic                   inWriteEnable,
  input  logic [REG_NUM_LOG-1:0] inWriteAddr,
  input  logic                   inMemToReg,
  input  logic [WORD_WIDTH-1:0]  inAluValue,
  input  logic [WORD_WIDTH-1:0]  inMemData,
  input  logic [2:0]             inLoadType,
  input  logic [1:0]             inByteOffset,
  output logic                   writeEnable,
  output logic [REG_NUM_LOG-1:0] writeAddr,
  output logic [WORD_WIDTH-1:0]  writeValue,
  output logic                   misalign,
  output logic [31:0]            retireCount
`ifdef WB_FWD_EN
  ,
  input  logic [REG_NUM_LOG-1:0] fwdAddr1,
  input  logic [REG_NUM_LOG-1:0] fwdAddr2,
  output logic                   fwdHit1,
  output logic                   fwdHit2,
  output logic [WORD_WIDTH-1:0]  fwdValue1,
  output logic [WORD_WIDTH-1:0]  fwdValue2
`endif
);

  // Load type encodings; 5..7 are reserved and treated as faulting loads.
  typedef enum logic [2:0] {
    LD_W  = 3'd0,
    LD_H  = 3'd1,
    LD_HU = 3'd2,
    LD_B  = 3'd3,
    LD_BU = 3'd4
  } loadType_t;

  logic                  cap;
  logic                  bad;
  logic                  loadBad;
  logic [7:0]            byteSel;
  logic [15:0]           halfSel;
  logic [WORD_WIDTH-1:0] loadValue;

  assign cap = inValid & ~flush;
  assign bad = inMemToReg & loadBad;

  // Select byte and halfword lanes from the little-endian memory word.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned; an unassigned path would infer a latch.
    byteSel = inMemData[7:0];
    halfSel = inByteOffset[1] ? inMemData[31:16] : inMemData[15:0];
    case (inByteOffset)
      2'd0: byteSel = inMemData[7:0];
      2'd1: byteSel = inMemData[15:8];
      2'd2: byteSel = inMemData[23:16];
      2'd3: byteSel = inMemData[31:24];
      default: byteSel = inMemData[7:0];
    endcase
  end

  // Extend the selected lane and flag misaligned or reserved load types.
  always_comb begin
    loadValue = inMemData;
    loadBad   = 1'b0;
    case (inLoadType)
      LD_W: begin
        loadValue = inMemData;
        loadBad   = (inByteOffset != 2'd0);
      end
      LD_H: begin
        loadValue = {{(WORD_WIDTH-16){halfSel[15]}}, halfSel};
        loadBad   = inByteOffset[0];
      end
      LD_HU: begin
        loadValue = {{(WORD_WIDTH-16){1'b0}}, halfSel};
        loadBad   = inByteOffset[0];
      end
      LD_B:  loadValue = {{(WORD_WIDTH-8){byteSel[7]}}, byteSel};
      LD_BU: loadValue = {{(WORD_WIDTH-8){1'b0}}, byteSel};
      default: loadBad = 1'b1;
    endcase
  end

  // MEM/WB pipeline register and retire counter.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      writeEnable <= 1'b0;
      writeAddr   <= '0;
      writeValue  <= '0;
      misalign    <= 1'b0;
      retireCount <= '0;
    end else if (cap) begin
      writeAddr   <= inWriteAddr;
      writeValue  <= inMemToReg ? loadValue : inAluValue;
      misalign    <= bad;
      writeEnable <= inWriteEnable & (inWriteAddr != '0) & ~bad;
      retireCount <= retireCount + 32'd1;
    end else begin
      writeEnable <= 1'b0;
      misalign    <= 1'b0;
    end
  end

`ifdef WB_FWD_EN
  // Bypass the value being written this cycle to decode's read ports.
  always_comb begin
    fwdHit1   = writeEnable & (writeAddr == fwdAddr1);
    fwdHit2   = writeEnable & (writeAddr == fwdAddr2);
    fwdValue1 = fwdHit1 ? writeValue : '0;
    fwdValue2 = fwdHit2 ? writeValue : '0;
  end
`endif

endmodule
